// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port memory behind the SPI slave: 2-bit opcode + payload,
// independent write/read pointers, and a valid/ready read-data return path.
module spi_ram_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              err,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WDATA = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   // Highest legal address; pointers wrap here rather than at 2**ADDR_W.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              err_q, err_d;
   logic              mem_we;

   logic [1:0]        opcode;
   logic [DATA_W-1:0] payload;
   logic              wr_in_range;
   logic              rd_in_range;

   assign opcode      = din[DATA_W+1:DATA_W];
   assign payload     = din[DATA_W-1:0];
   assign wr_in_range = (wr_ptr_q <= LAST_ADDR);
   assign rd_in_range = (rd_ptr_q <= LAST_ADDR);

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         err_q    <= err_d;
      end
   end

   // Memory array has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= payload;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      err_d    = err_q;
      mem_we   = 1'b0;

      // Pending word accepted; a READ below may immediately re-arm HOLD.
      if (state_q == HOLD && tx_ready) begin
         state_d = IDLE;
      end

      if (rx_valid) begin
         case (opcode)
            OP_WADDR: wr_ptr_d = payload[ADDR_W-1:0];
            OP_WDATA: begin
               if (wr_in_range) begin
                  mem_we = 1'b1;
                  if (AUTO_INC != 0) begin
                     wr_ptr_d = next_ptr(wr_ptr_q);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_RADDR: rd_ptr_d = payload[ADDR_W-1:0];
            OP_READ: begin
               // Overrun: a word is still pending and not taken this edge.
               if (state_q == HOLD && !tx_ready) begin
                  err_d = 1'b1;
               end else begin
                  state_d = HOLD;
                  if (rd_in_range) begin
                     dout_d = mem_q[rd_ptr_q];
                     if (AUTO_INC != 0) begin
                        rd_ptr_d = next_ptr(rd_ptr_q);
                     end
                  end else begin
                     dout_d = '0;
                     err_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dout     = dout_q;
   assign tx_valid = (state_q == HOLD);
   assign err      = err_q;
   assign wr_ptr   = wr_ptr_q;
   assign rd_ptr   = rd_ptr_q;

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised command-decoded single-port memory behind the SPI slave front end. It receives (DATA_W+2)-bit command words from the SPI receive path: a 2-bit opcode plus a DATA_W-bit payload. It maintains separate write and read address pointers with optional auto-increment and wrap. It returns read data to the SPI transmit path through a valid/ready handshake, and flags protocol errors.

## Interface
- DATA_W, 8, width of memory word and command payload.
- ADDR_W, 8, width of address pointers; payload bits [ADDR_W-1:0] carry addresses (requires ADDR_W <= DATA_W).
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, 1 = pointer post-increments after each data write / read; 0 = pointers change only on address commands.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  DATA_W+2  command word; din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle; a command executes only at an edge where rx_valid=1.
- tx_ready  in  1  transmit path accepts dout this cycle.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid, held until accepted.
- err  out  1  sticky error flag; cleared only by reset.
- wr_ptr  out  ADDR_W  current write pointer (status).
- rd_ptr  out  ADDR_W  current read pointer (status).

## Operation
- Reset (rst_n=0 at an edge): wr_ptr=0, rd_ptr=0, dout=0, tx_valid=0, err=0, FSM=IDLE. Memory contents are not reset.
- Opcodes are decoded only when rx_valid=1:
  - 00 WADDR: wr_ptr <= payload[ADDR_W-1:0].
  - 01 WDATA: mem[wr_ptr] <= payload; if AUTO_INC, wr_ptr <= next(wr_ptr).
  - 10 RADDR: rd_ptr <= payload[ADDR_W-1:0].
  - 11 READ: dout <= mem[rd_ptr]; tx_valid <= 1; if AUTO_INC, rd_ptr <= next(rd_ptr). The payload is ignored.
- next(p) = (p == MEM_DEPTH-1) ? 0 : p+1. Pointers wrap at MEM_DEPTH, not at 2**ADDR_W.
- Out-of-range pointer (p >= MEM_DEPTH, possible only when MEM_DEPTH < 2**ADDR_W):
  - WDATA: the write is suppressed, the pointer is left unchanged, and err <= 1.
  - READ: dout <= 0, tx_valid <= 1, err <= 1, and the pointer is left unchanged.
- The FSM has two states:
  - IDLE (tx_valid=0): a READ moves the FSM to HOLD.
  - HOLD (tx_valid=1): tx_ready=1 with no READ returns to IDLE with tx_valid <= 0. dout is held stable while in HOLD.
- READ in HOLD with tx_ready=1 at the same edge: the old word counts as accepted and the new word loads. tx_valid stays 1 and the FSM stays in HOLD.
- READ in HOLD with tx_ready=0 (overrun): the command is dropped. dout, rd_ptr and tx_valid are unchanged, and err <= 1.
- Opcodes 00, 01 and 10 execute normally in either state and do not affect tx_valid.
- Reset applied in HOLD drops the pending word: tx_valid=0 on the next cycle.

## Timing
- All command effects are visible in the cycle after the accepting edge (1-cycle latency).
- Back-to-back WDATA commands are accepted every cycle.
- WDATA at edge N followed by a READ of the same address at edge N+1 returns the new data.
- Memory is a synchronous write, registered-read array. There is no read-during-write conflict, because one command executes per edge.
- The handshake transfers on an edge where tx_valid=1 and tx_ready=1.
- tx_ready while tx_valid=0 is ignored.
- Maximum read throughput is one word per cycle, achieved with READ and tx_ready both asserted every cycle.

## Test plan
- Reset, then WADDR 0x10 followed by WDATA 0xA5, 0x5A (AUTO_INC=1) -> mem[0x10]=0xA5, mem[0x11]=0x5A, wr_ptr=0x12. Then RADDR 0x10 and two READs, each accepted with tx_ready=1 -> dout 0xA5 then 0x5A, rd_ptr=0x12, err=0.
- Wrap: WADDR 0xFF, then WDATA 0x11 and WDATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_ptr=0x01.
- Handshake hold: READ with tx_ready=0 for 3 cycles -> tx_valid=1 and dout stable throughout. A second READ during the hold -> dropped, err=1, rd_ptr unchanged. tx_ready=1 -> tx_valid=0 on the next cycle.
- Streaming: READ and tx_ready asserted together for 4 consecutive cycles from rd_ptr=0 -> tx_valid stays 1, dout = mem[0..3] on successive cycles, err=0.
- Range and mode checks:
  - MEM_DEPTH=200, AUTO_INC=0: WADDR 0xC8 then WDATA 0x33 -> no write, err=1. RADDR 0xC8 then READ -> dout=0.
  - With AUTO_INC=0, repeated READs at rd_ptr=0x05 return the same word and leave rd_ptr=0x05.
- Reset mid-HOLD -> tx_valid=0, dout=0, pointers=0 on the next cycle. rx_valid=0 with din=0x3FF -> no state change.
